mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as the responder on the processor data-memory port (we/a/wd/rd). It sits beside the data memory in the single-cycle top.
- Stores are decoded into register writes; loads return status combinationally in the same cycle, matching single-cycle load timing.
- Written bytes are queued in a small FIFO and serialised as 8N1 frames on tx.

---
 rtl/mmio_uart_tx.sv | 154 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the single-cycle data-memory port.
// Stores hit a 16-byte register window; loads return status combinationally.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_STATUS  = 2'd1,
    REG_BAUDDIV = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud;
  logic [15:0]   div_q;
  logic [15:0]   bitcnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic     hit, full, empty, push_req, push_ok, pop, bit_end;
  reg_sel_t sel;
  logic     unused;

  assign hit      = (a[31:4] == BASE_ADDR[31:4]);
  assign sel      = reg_sel_t'(a[3:2]);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = we && hit && (sel == REG_TXDATA);
  assign pop      = (state == IDLE) && !empty;
  // A same-cycle pop frees the slot, so a push to a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign bit_end  = (bitcnt == div_q - 16'd1);
  assign busy     = (state != IDLE) || !empty;
  assign unused   = ^{a[1:0], wd[31:16]};

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    rd = '0;
    if (hit) begin
      case (sel)
        REG_STATUS:  rd = {24'd0, 4'(count), overflow, busy, empty, full};
        REG_BAUDDIV: rd = {16'd0, baud};
        default:     rd = '0;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; count and pointers alone define validity.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wptr] <= wd[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud     <= DIV_RESET;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (we && hit && (sel == REG_STATUS) && wd[3])
        overflow <= 1'b0;
      if (we && hit && (sel == REG_BAUDDIV))
        baud <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    end
  end

  // tx is registered from the state, so the line lags the FSM by one cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      tx     <= 1'b1;
      div_q  <= 16'd1;
      bitcnt <= '0;
      idx    <= '0;
      shift  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift  <= mem[rptr];
            div_q  <= baud;
            bitcnt <= '0;
            state  <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            bitcnt <= '0;
            idx    <= '0;
            state  <= DATA;
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            bitcnt <= '0;
            shift  <= {1'b0, shift[7:1]};
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            bitcnt <= '0;
            state  <= IDLE;
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode, FIFO/overflow behaviour,
// frame timing against a per-cycle line model, baud changes and mid-frame reset.
module tb_mmio_uart_tx;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b1;
  logic        we      = 1'b0;
  logic [31:0] a       = '0;
  logic [31:0] wd      = '0;
  logic [31:0] rd;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .BASE_ADDR (32'h0000_1000),
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd868)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .we     (we),
    .a      (a),
    .wd     (wd),
    .rd     (rd),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Line recorder: bit k holds tx/busy sampled on the falling edge after
  // the k-th rising edge counted from rec_base.
  logic         rec_on   = 1'b0;
  int unsigned  rec_base = 0;
  logic [255:0] tx_log;
  logic [255:0] busy_log;
  always @(negedge Clk) begin
    if (rec_on && (cyc - rec_base) < 256) begin
      tx_log[8'(cyc - rec_base)]   <= tx;
      busy_log[8'(cyc - rec_base)] <= busy;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%064h expected 0x%064h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge Clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge Clk);
    #1;
    we = 1'b0; a = '0; wd = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge Clk);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic rec_start();
    rec_base = cyc;
    rec_on   = 1'b1;
  endtask

  task automatic rec_finish(input int n, output logic [255:0] mask);
    wait_cyc(rec_base + n);
    rec_on = 1'b0;
    mask   = (256'd1 << n) - 256'd1;
  endtask

  // Expected tx k rising edges after the store edge of a byte that is popped
  // on the next edge: 2 idle-high samples, start, 8 data LSB first, stop.
  function automatic logic f_tx(input logic [7:0] b, input int div, input int k);
    if (k < 2)           return 1'b1;
    if (k < 2 + div)     return 1'b0;
    if (k < 2 + 9 * div) return b[3'((k - 2 - div) / div)];
    return 1'b1;
  endfunction

  // Waits for a start bit, then samples each bit mid-cell.
  task automatic rx_byte(input int div, output logic [7:0] b, output int unsigned t_start);
    int n   = 0;
    int pos = 0;
    b = '0;
    @(negedge Clk);
    while (tx !== 1'b0 && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check("rx_start_seen", 32'(n < 5000), 32'd1);
    t_start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (div * (1 + i) + div / 2 - pos) @(negedge Clk);
      pos  = div * (1 + i) + div / 2;
      b[i] = tx;
    end
    repeat (div * 9 + div / 2 - pos) @(negedge Clk);
    check("rx_stop_bit", 32'(tx), 32'd1);
  endtask

  logic [255:0] exp_tx, exp_busy, mask;
  logic [7:0]   rx_b;
  int unsigned  base, t_st, t_prev;
  logic [7:0]   exp_seq [5] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA7};

  initial begin
    // Reset state
    #1 Reset_n = 1'b0;
    #2;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    read_check("reset_status", 32'h1004, 32'h0000_0002);
    read_check("reset_bauddiv", 32'h1008, 32'd868);
    read_check("reset_txdata_reads0", 32'h1000, 32'd0);
    read_check("reset_rsvd_reads0", 32'h100C, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single byte at DIV=4
    store(32'h1008, 32'd4);
    read_check("bauddiv_4", 32'h1008, 32'd4);
    store(32'h1000, 32'h0000_0055);
    rec_start();
    rec_finish(44, mask);
    exp_tx = '0; exp_busy = '0;
    for (int k = 0; k < 44; k++) begin
      exp_tx[8'(k)]   = f_tx(8'h55, 4, k);
      exp_busy[8'(k)] = (k <= 40);
    end
    check_vec("frame55_tx", tx_log & mask, exp_tx);
    check_vec("frame55_busy", busy_log & mask, exp_busy);
    read_check("idle_status", 32'h1004, 32'h0000_0002);

    // Overflow at DIV=100: first byte popped, four queued, sixth dropped
    store(32'h1008, 32'd100);
    store(32'h1000, 32'h0000_00A1);
    base = cyc;
    for (int i = 2; i <= 6; i++) store(32'h1000, 32'h0000_00A0 + 32'(i));
    read_check("ovf_status", 32'h1004, 32'h0000_004D);
    store(32'h1004, 32'h0000_0008);
    read_check("ovf_cleared", 32'h1006, 32'h0000_0045);

    // Store in the same cycle as the pop that ends the first frame's IDLE gap
    wait_cyc(base + 1001);
    store(32'h1000, 32'h0000_00A7);
    read_check("pushpop_status", 32'h1004, 32'h0000_0045);
    t_prev = base + 2;
    for (int i = 0; i < 5; i++) begin
      rx_byte(100, rx_b, t_st);
      check($sformatf("rx_byte%0d", i), 32'(rx_b), 32'(exp_seq[i]));
      check($sformatf("rx_gap%0d", i), t_st - t_prev, (i == 0) ? 32'd1001 : 32'd1001);
      t_prev = t_st;
    end
    for (int n = 0; n < 200 && busy; n++) @(negedge Clk);
    read_check("drained_status", 32'h1004, 32'h0000_0002);

    // BAUDDIV=0 is stored as 1: ten-cycle frame
    store(32'h1008, 32'd0);
    read_check("bauddiv_0_as_1", 32'h1008, 32'd1);
    store(32'h1000, 32'h0000_003C);
    rec_start();
    rec_finish(14, mask);
    exp_tx = '0; exp_busy = '0;
    for (int k = 0; k < 14; k++) begin
      exp_tx[8'(k)]   = f_tx(8'h3C, 1, k);
      exp_busy[8'(k)] = (k <= 10);
    end
    check_vec("div1_tx", tx_log & mask, exp_tx);
    check_vec("div1_busy", busy_log & mask, exp_busy);

    // BAUDDIV written mid-frame applies only to the following frame
    store(32'h1008, 32'd4);
    store(32'h1000, 32'h0000_00C3);
    rec_start();
    store(32'h1000, 32'h0000_0096);
    store(32'h1008, 32'd8);
    rec_finish(130, mask);
    exp_tx = '0; exp_busy = '0;
    for (int k = 0; k < 130; k++) begin
      exp_tx[8'(k)]   = (k < 42) ? f_tx(8'hC3, 4, k) : f_tx(8'h96, 8, k - 41);
      exp_busy[8'(k)] = (k <= 121);
    end
    check_vec("divchg_tx", tx_log & mask, exp_tx);
    check_vec("divchg_busy", busy_log & mask, exp_busy);
    read_check("bauddiv_8", 32'h100B, 32'd8);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0)
    store(32'h1000, 32'h0000_00A5);
    base = cyc;
    wait_cyc(base + 37);
    check("midframe_tx_low", 32'(tx), 32'd0);
    a = 32'h1004;
    #2 Reset_n = 1'b0;
    #1;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_status", rd, 32'h0000_0002);
    read_check("midreset_bauddiv", 32'h1008, 32'd868);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Address decode: misses and the reserved register do nothing
    store(32'h2000, 32'h0000_0077);
    rec_start();
    store(32'h100C, 32'h1234_5678);
    rec_finish(20, mask);
    check_vec("miss_tx_idle", tx_log & mask, mask);
    check_vec("miss_busy_low", busy_log & mask, 256'd0);
    read_check("miss_rd0", 32'h2000, 32'd0);
    read_check("miss_status_alias", 32'h2004, 32'd0);
    read_check("rsvd_rd0", 32'h100C, 32'd0);
    read_check("final_status", 32'h1004, 32'h0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
